// File: rtl/mont_pkg.sv
// Shared types and widths for the bit-serial Montgomery multiplier.
// The accumulator is two bits wider than the operands so that C < 2M (plus B) always fits.
package mont_pkg;
    localparam int MONT_N  = 512;
    localparam int MONT_W  = MONT_N + 2;
    localparam int MONT_CW = $clog2(MONT_N);

    typedef enum logic [2:0] {
        IDLE,
        ADDB,
        ADDM,
        SUB,
        DONE
    } mont_state_t;
endpackage

// File: rtl/mont_datapath.sv
// Single shared adder for ADDB (acc+B), ADDM ((acc+M)>>1) and SUB (acc-M with borrow).
// Purely combinational; subtraction is acc + ~addend + 1 so one carry chain serves every step.
module mont_datapath
    import mont_pkg::*;
#(
    parameter int W = MONT_W
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] addend,
    input  logic         add_en,
    input  logic         sub,
    input  logic         shift,
    output logic [W-1:0] sum,
    output logic         borrow
);
    logic [W-1:0] opnd;
    logic [W:0]   raw;

    always_comb begin
        opnd   = add_en ? (sub ? ~addend : addend) : '0;
        raw    = {1'b0, acc} + {1'b0, opnd} + {{W{1'b0}}, sub};
        // Shifting out of raw keeps the carry bit, so the sum is exact before halving.
        sum    = shift ? raw[W:1] : raw[W-1:0];
        borrow = sub & ~raw[W];
    end
endmodule

// File: rtl/montgomery_mul.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-N mod M (M odd, A,B < M).
// Define MONT_ZERO_SKIP_EN to skip ADDB for zero bits of A (data-dependent latency).
module montgomery_mul
    import mont_pkg::*;
#(
    parameter int N = MONT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);
    localparam int W  = N + 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mont_state_t  state;
    mont_state_t  step_idle;
    mont_state_t  step_addm;
    logic [N-1:0] a_sr;
    logic [N-1:0] b_q;
    logic [N-1:0] m_q;
    logic [W-1:0] c_q;
    logic [CW-1:0] idx;

    logic [W-1:0] dp_addend;
    logic [W-1:0] dp_sum;
    logic         dp_add_en;
    logic         dp_sub;
    logic         dp_shift;
    logic         dp_borrow;

    // Step taken for the next bit of A: a_sr[0] is the current bit, a_sr[1] the next.
`ifdef MONT_ZERO_SKIP_EN
    assign step_idle = in_a[0] ? ADDB : ADDM;
    assign step_addm = a_sr[1] ? ADDB : ADDM;
`else
    assign step_idle = ADDB;
    assign step_addm = ADDB;
`endif

    always_comb begin
        dp_addend = '0;
        dp_add_en = 1'b0;
        dp_sub    = 1'b0;
        dp_shift  = 1'b0;
        case (state)
            ADDB: begin
                dp_addend = {2'b00, b_q};
                dp_add_en = a_sr[0];
            end
            ADDM: begin
                dp_addend = {2'b00, m_q};
                dp_add_en = c_q[0];
                dp_shift  = 1'b1;
            end
            SUB: begin
                dp_addend = {2'b00, m_q};
                dp_add_en = 1'b1;
                dp_sub    = 1'b1;
            end
            default: ;
        endcase
    end

    mont_datapath #(.W(W)) u_dp (
        .acc    (c_q),
        .addend (dp_addend),
        .add_en (dp_add_en),
        .sub    (dp_sub),
        .shift  (dp_shift),
        .sum    (dp_sum),
        .borrow (dp_borrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_q    <= '0;
            m_q    <= '0;
            c_q    <= '0;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= in_a;
                        b_q   <= in_b;
                        m_q   <= in_m;
                        c_q   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= step_idle;
                    end
                end
                ADDB: begin
                    c_q   <= dp_sum;
                    state <= ADDM;
                end
                ADDM: begin
                    c_q  <= dp_sum;
                    a_sr <= a_sr >> 1;
                    if (idx == CW'(N - 1)) begin
                        state <= SUB;
                    end else begin
                        idx   <= idx + CW'(1);
                        state <= step_addm;
                    end
                end
                SUB: begin
                    result <= dp_borrow ? c_q[N-1:0] : dp_sum[N-1:0];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
